// File: rtl/latch_gate_tx.sv
// -----------------------------------------------------------------------------
// latch_gate_tx
//
// Transmitter end of the gated-latch capture interface. A parallel word is
// accepted over a valid/ready handshake and shifted out LSB first on a
// data/gate pair that drives a downstream gated D latch. Each bit has a
// setup, gate-open and hold phase so the latch never sees D move while its
// gate is open, or on the edge where the gate opens or closes.
//
// Optional feature (compile-time macro): LATCH_TX_READBACK_EN
//   Defined     : LatchQ is sampled at the edge ending the first hold cycle
//                 of every bit and compared with LatchD. A mismatch sets the
//                 sticky ErrFlag and bumps the saturating ErrCnt.
//   Not defined : LatchQ is ignored; ErrFlag and ErrCnt are constant 0.
//
// Ports:
//   Clk      in   rising-edge clock, single domain
//   Reset    in   synchronous, active-high reset
//   TxData   in   word to send, sampled on accept
//   TxValid  in   TxData valid
//   TxReady  out  block can accept a word (IDLE)
//   LatchD   out  serial data to latch D input, registered
//   LatchG   out  gate to latch Clk input, registered
//   BitIdx   out  index of the bit currently on LatchD
//   Busy     out  frame in progress
//   Done     out  one-cycle pulse in the first IDLE cycle after a frame
//   LatchQ   in   latch Q readback
//   ErrFlag  out  sticky readback mismatch
//   ErrCnt   out  saturating readback mismatch count
// -----------------------------------------------------------------------------
module latch_gate_tx #(
   parameter int DATA_W    = 8,
   parameter int SETUP_CYC = 2,
   parameter int GATE_CYC  = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic                                           Clk,
   input  logic                                           Reset,
   input  logic [DATA_W-1:0]                              TxData,
   input  logic                                           TxValid,
   output logic                                           TxReady,
   output logic                                           LatchD,
   output logic                                           LatchG,
   output logic [((DATA_W > 1) ? $clog2(DATA_W) : 1)-1:0] BitIdx,
   output logic                                           Busy,
   output logic                                           Done,
   input  logic                                           LatchQ,
   output logic                                           ErrFlag,
   output logic [7:0]                                     ErrCnt
);

   localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int MAX_SG  = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
   localparam int MAX_CYC = (MAX_SG > HOLD_CYC) ? MAX_SG : HOLD_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETUP, GATE, HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;     // cycles spent in the current phase, minus one
   logic [DATA_W-1:0] shreg;   // bits still to be sent; bit 0 is the next one

   // Every output is assigned only on a phase transition, so LatchD and LatchG
   // can never move together and LatchD is frozen for the whole gate window.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         shreg   <= '0;
         LatchD  <= 1'b0;
         LatchG  <= 1'b0;
         BitIdx  <= '0;
         TxReady <= 1'b1;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (TxValid) begin
                  shreg   <= TxData >> 1;
                  LatchD  <= TxData[0];
                  BitIdx  <= '0;
                  cnt     <= '0;
                  TxReady <= 1'b0;
                  Busy    <= 1'b1;
                  state   <= SETUP;
               end
            end

            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt    <= '0;
                  LatchG <= 1'b1;
                  state  <= GATE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            GATE: begin
               if (cnt == GATE_LAST) begin
                  cnt    <= '0;
                  LatchG <= 1'b0;
                  state  <= HOLD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt <= '0;
                  if (BitIdx != LAST_IDX) begin
                     BitIdx <= BitIdx + IDX_W'(1);
                     LatchD <= shreg[0];
                     shreg  <= shreg >> 1;
                     state  <= SETUP;
                  end else begin
                     TxReady <= 1'b1;
                     Busy    <= 1'b0;
                     Done    <= 1'b1;
                     state   <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               LatchG  <= 1'b0;
               TxReady <= 1'b1;
               Busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

`ifdef LATCH_TX_READBACK_EN
   // The latch has been transparent through the gate window and has just
   // closed, so at the end of the first hold cycle Q must equal D.
   logic sample_q;
   assign sample_q = (state == HOLD) && (cnt == '0);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ErrFlag <= 1'b0;
         ErrCnt  <= '0;
      end else if (sample_q && (LatchQ != LatchD)) begin
         ErrFlag <= 1'b1;
         if (ErrCnt != 8'hFF) begin
            ErrCnt <= ErrCnt + 8'd1;
         end
      end
   end
`else
   logic unused_latch_q;
   assign unused_latch_q = LatchQ;
   assign ErrFlag        = 1'b0;
   assign ErrCnt         = '0;
`endif

endmodule
